// File: rtl/alu_seq.sv
// Sequential ALU: W-bit operands, 2W-bit registered result, start/busy/done handshake.
// Single-cycle ops complete on the start edge; multiply is a W-cycle shift-add.
module alu_seq #(
    parameter int unsigned W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [2:0]        op,
    input  logic              use_acc,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2*W-1:0]    result
);

    localparam int unsigned RW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [2:0]  OP_MUL = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t          state;
    logic [RW-1:0]   mcand;
    logic [W-1:0]    mplier;
    logic [RW-1:0]   product;
    logic [CW-1:0]   count;

    logic [W-1:0]    beff_c;
    logic [RW-1:0]   alu_c;
    logic [RW-1:0]   addend_c;
    logic [RW-1:0]   product_next_c;

    // Accumulate mode feeds the low half of the previous result back as B.
    always_comb begin
        beff_c = use_acc ? result[W-1:0] : b;
    end

    // Single-cycle op results; multiply and reserved op yield 0 here.
    always_comb begin
        alu_c = '0;
        case (op)
            3'd0: alu_c = {a, beff_c};
            3'd1: alu_c = RW'({1'b0, a} + {1'b0, beff_c});
            3'd2: alu_c = {a | beff_c, a ^ beff_c};
            3'd3: alu_c[0] = |{a, beff_c};
            3'd4: alu_c[0] = ~(^{a, beff_c});
            3'd5: begin
                if (32'(beff_c) < RW) begin
                    alu_c = RW'(a) << beff_c;
                end
            end
            default: alu_c = '0;
        endcase
    end

    // One shift-add step of the multiply.
    always_comb begin
        addend_c       = mplier[count] ? (mcand << count) : '0;
        product_next_c = product + addend_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand   <= RW'(a);
                            mplier  <= beff_c;
                            product <= '0;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= MULT;
                        end else begin
                            result <= alu_c;
                            done   <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    product <= product_next_c;
                    count   <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        result <= product_next_c;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=4): vector table for single-cycle ops,
// hand sequences for reset, multiply timing and mid-multiply abort.
module tb_alu_seq;

    localparam int unsigned W = 4;

    typedef struct {
        logic [2:0] op;
        logic       acc;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       use_acc;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];
    logic [7:0] prev;

    alu_seq #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .op      (op),
        .use_acc (use_acc),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        // Sequential table: accumulate entries depend on the preceding result.
        vecs[0]  = '{3'd1, 1'b0, 4'hF, 4'h1, 8'h10};
        vecs[1]  = '{3'd1, 1'b1, 4'h1, 4'h7, 8'h01};
        vecs[2]  = '{3'd2, 1'b0, 4'hC, 4'hA, 8'hE6};
        vecs[3]  = '{3'd4, 1'b0, 4'h3, 4'h0, 8'h01};
        vecs[4]  = '{3'd4, 1'b0, 4'h1, 4'h0, 8'h00};
        vecs[5]  = '{3'd5, 1'b0, 4'h1, 4'h7, 8'h80};
        vecs[6]  = '{3'd5, 1'b0, 4'h1, 4'h9, 8'h00};
        vecs[7]  = '{3'd5, 1'b0, 4'hF, 4'h4, 8'hF0};
        vecs[8]  = '{3'd3, 1'b0, 4'h0, 4'h0, 8'h00};
        vecs[9]  = '{3'd3, 1'b0, 4'h0, 4'h1, 8'h01};
        vecs[10] = '{3'd7, 1'b0, 4'hF, 4'hF, 8'h00};
        vecs[11] = '{3'd1, 1'b1, 4'h2, 4'hF, 8'h02};
        vecs[12] = '{3'd1, 1'b1, 4'h3, 4'hF, 8'h05};
        vecs[13] = '{3'd0, 1'b1, 4'h9, 4'h0, 8'h95};

        // Reset with a start request held: nothing may issue.
        reset = 1'b1; start = 1'b1; op = 3'd1; a = 4'hF; b = 4'h1; use_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 8'h00);
        check("reset_busy", 8'(busy), 8'h00);
        check("reset_done", 8'(done), 8'h00);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_done", 8'(done), 8'h00);

        // Concatenate, then confirm done drops and result holds.
        @(negedge clk);
        op = 3'd0; a = 4'hA; b = 4'h3; start = 1'b1;
        @(posedge clk);
        #1;
        check("cat_result", result, 8'hA3);
        check("cat_done", 8'(done), 8'h01);
        @(negedge clk);
        start = 1'b0; a = 4'h0; b = 4'h0;
        @(posedge clk);
        #1;
        check("cat_done_drop", 8'(done), 8'h00);
        check("cat_hold", result, 8'hA3);

        // Back-to-back single-cycle ops from the table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            op = vecs[i].op; use_acc = vecs[i].acc; a = vecs[i].a; b = vecs[i].b;
            start = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            check($sformatf("vec%0d_done", i), 8'(done), 8'h01);
        end
        prev = vecs[NV-1].exp;
        @(negedge clk);
        start = 1'b0; use_acc = 1'b0;

        // Multiply 15*15 with stray starts while busy and on the completion cycle.
        @(negedge clk);
        op = 3'd6; a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("mul_busy%0d", i), 8'(busy), 8'h01);
            check($sformatf("mul_nodone%0d", i), 8'(done), 8'h00);
            check($sformatf("mul_hold%0d", i), result, prev);
            op = 3'd0; a = 4'h1; b = 4'h2; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("mul_result", result, 8'hE1);
        check("mul_done", 8'(done), 8'h01);
        check("mul_busy_drop", 8'(busy), 8'h00);
        @(negedge clk);
        check("mul_done_drop", 8'(done), 8'h00);
        check("mul_after_hold", result, 8'hE1);

        // Reset during the second busy cycle aborts the multiply.
        @(negedge clk);
        op = 3'd6; a = 4'hF; b = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy1", 8'(busy), 8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", result, 8'h00);
        check("abort_busy", 8'(busy), 8'h00);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort_nodone%0d", i), 8'(done), 8'h00);
            @(negedge clk);
        end

        // Fresh multiply after the abort: 3*5.
        op = 3'd6; a = 4'h3; b = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mul2_pending", result, 8'h00);
        @(negedge clk);
        check("mul2_result", result, 8'h0F);
        check("mul2_done", 8'(done), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor of the lab ALU: W-bit operands, 2W-bit result held in a result register, driven by a start/busy/done handshake.
- Generalises the lab op set to any width:
  - add now keeps its carry;
  - new shift-left op;
  - new sequential shift-add multiply taking W cycles.
- Operand B can be taken from the low half of the previous result (accumulate mode).
- Sits between the board switches/keys and the HEX/LEDR display logic.

Parameters:
- W, 4, operand width in bits (W >= 2); result width is 2W.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- a  in  W  operand A
- b  in  W  operand B
- op  in  3  operation select, sampled with start
- use_acc  in  1  1: effective B = result[W-1:0]; 0: B = b; sampled with start
- start  in  1  request; accepted only when busy=0
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse when result is updated
- result  out  2W  registered result

Behaviour:
- Reset:
  - One clk edge with reset=1 clears state to IDLE.
  - result=0, done=0, busy=0, internal counters/product=0.
  - Reset overrides start and any in-flight multiply; the aborted op never completes.
- Operand sampling:
  - On an accepted start, a, op and beff = (use_acc ? result[W-1:0] : b) are sampled.
  - Later input changes have no effect on that operation.
- Ops (zero-extend everything to 2W):
  - 0: {a, beff}
  - 1: a + beff as a (W+1)-bit sum, carry in bit W, upper bits 0
  - 2: {a | beff, a ^ beff}
  - 3: result[0] = OR-reduce of {a, beff}, rest 0
  - 4: result[0] = 1 if popcount({a, beff}) is even, rest 0
  - 5: {0, a} << beff; shift amounts >= 2W give 0
  - 6: a * beff, unsigned, multi-cycle
  - 7: result = 0 (reserved op still completes normally)
- FSM states: IDLE, MULT.
- IDLE, start=1, op != 6:
  - Same edge: result <= f(op), done <= 1, stay IDLE.
  - Latency 1: done and the new result are visible together in the next cycle.
- IDLE, start=1, op = 6:
  - Same edge: latch multiplicand/multiplier, product <= 0, count <= 0, busy <= 1, go to MULT.
  - result holds its old value.
- MULT, each edge:
  - If multiplier bit[count]=1, product += multiplicand << count.
  - count++.
  - On the W-th MULT edge: result <= final product, done <= 1, busy <= 0, go to IDLE.
  - Result/done appear W cycles after the start edge.
- Start while busy=1 is ignored, not queued.
- Start in the same cycle that MULT completes is ignored; it is accepted from the following cycle.
- done:
  - High for exactly one cycle per completed op.
  - Back-to-back single-cycle starts give done high on consecutive cycles.
- result holds its value between completions; it changes only on completion or reset.
- use_acc after reset reads 0 (result=0).
- The multiply product never overflows 2W bits.
- No combinational path from inputs to outputs.

Test Plan (W=4):
- Reset with start=1, op=1 held -> result=8'h00, busy=0, done=0; nothing issued during reset.
- op=0, a=4'hA, b=4'h3, start 1 cycle -> next cycle result=8'hA3, done=1; following cycle done=0 and result holds 8'hA3.
- Add then accumulate:
  - op=1, a=4'hF, b=4'h1 -> result=8'h10 (carry kept).
  - Then op=1, use_acc=1, a=4'h1 -> beff=0, result=8'h01.
- Logic and shift ops:
  - op=2, a=4'hC, b=4'hA -> 8'hE6.
  - op=4, a=4'h3, b=4'h0 -> 8'h01; a=4'h1 -> 8'h00.
  - op=5, a=4'h1, b=4'h7 -> 8'h80; b=4'h9 -> 8'h00.
- Multiply:
  - op=6, a=4'hF, b=4'hF, start -> busy=1 for 4 cycles, result unchanged meanwhile.
  - done=1 with result=8'hE1 on cycle 4; extra start pulses during busy do not alter the result or add done pulses.
- Reset mid-multiply:
  - op=6 start, reset on 2nd busy cycle -> result=0, busy=0, no done pulse.
  - Then op=6, a=4'h3, b=4'h5 -> result=8'h0F after 4 cycles.
